instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h00: program-counter value loaded on reset.
REQ-002 clk  input  1  single clock for all state; every flop updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  run permission; low parks the unit in IDLE.
REQ-005 imem_req  output  1  instruction-memory read request, registered.
REQ-006 imem_addr  output  8  read address, equal to pc while imem_req is high.
REQ-007 imem_ack  input  1  memory has valid imem_data this cycle.
REQ-008 imem_data  input  8  instruction word: [7:5] opcode, [4:0] signed offset or operand.
REQ-009 OPCode  output  3  opcode to the control unit, registered.
REQ-010 operand  output  5  instruction bits [4:0], registered.
REQ-011 instr_valid  output  1  OPCode/operand are valid and held stable.
REQ-012 instr_ready  input  1  execute stage accepts the issued instruction.
REQ-013 J, JC, NEQ  input  1 each  decoded branch controls returned by the control unit for the issued OPCode.
REQ-014 eq_flag  input  1  register-compare equality result for the issued instruction.
REQ-015 pc  output  8  address of the current instruction.
REQ-016 retired  output  16  count of accepted instructions.

Function
REQ-017 FSM states are IDLE, FETCH and ISSUE; the unit SHALL hold exactly one state at a time.
REQ-018 IDLE: enable=1 -> next state FETCH with imem_req=1; otherwise the unit stays in IDLE.
REQ-019 FETCH: imem_req=1 and imem_addr=pc every cycle until imem_ack=1 is sampled.
REQ-020 On imem_ack in FETCH: capture imem_data[7:5] into OPCode and [4:0] into operand; next state ISSUE; imem_req=0 and instr_valid=1 from the next cycle.
REQ-021 Minimum latency: ack in the first FETCH cycle -> instr_valid high on the following edge, giving 2 cycles from request to issue.
REQ-022 ISSUE: instr_valid=1 and OPCode/operand held unchanged until instr_valid & instr_ready is sampled (handshake).
REQ-023 Branch decision, evaluated only on the handshake cycle: taken = J | (JC & (eq_flag ^ NEQ)); JCE is taken on eq_flag=1, JCN on eq_flag=0.
REQ-024 Next pc: taken -> pc + sign_extend(operand) modulo 256; not taken -> pc + 1 modulo 256; 8'hFF+1 wraps to 8'h00.
REQ-025 On the handshake: retired increments by 1, wrapping 16'hFFFF -> 16'h0000; instr_valid falls the next cycle.
REQ-026 After the handshake: enable=1 -> FETCH; enable=0 -> IDLE. enable is ignored in FETCH and ISSUE, so an in-flight instruction always completes.
REQ-027 J, JC, NEQ and eq_flag SHALL be ignored outside the handshake cycle.
REQ-028 imem_ack outside FETCH SHALL be ignored; imem_data SHALL be ignored without imem_ack.
REQ-029 Offset 5'b00000 on a taken jump leaves pc unchanged (self-loop is legal).

Reset
REQ-030 While rst_n=0, independent of clk: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, OPCode=3'b000, operand=5'b00000, retired=16'h0000.
REQ-031 Reset mid-FETCH or mid-ISSUE abandons the pending transaction; a late imem_ack after release SHALL be ignored.
REQ-032 Operation resumes on the first clk edge after rst_n rises, starting from IDLE.

Verification
REQ-033 Reset release, enable=1, memory acks immediately with 8'h00 and instr_ready=1 -> pc steps 0,1,2; instr_valid pulses every 2 cycles; retired=3 after the third handshake.
REQ-034 pc=8'h10, imem_data=8'b100_11110 with J=1 -> OPCode=3'b100, operand=5'h1E; next imem_addr=8'h0E.
REQ-035 JC=1, NEQ=0, eq_flag=0, offset +4 at pc=8'h20 -> next pc=8'h21; repeat with eq_flag=1 -> next pc=8'h24; JC=1, NEQ=1, eq_flag=0 -> next pc=8'h24.
REQ-036 imem_ack delayed 3 cycles and instr_ready held low 4 cycles -> imem_req held high for 4 cycles with a stable address; OPCode stable through the stall; retired increments only once.
REQ-037 pc=8'hFF, not taken -> pc=8'h00; retired preloaded at 16'hFFFF -> wraps to 16'h0000 on the handshake.
REQ-038 rst_n pulsed low mid-FETCH, followed by a stray imem_ack -> all outputs return to the REQ-030 values immediately; no issue occurs until a fresh FETCH completes at pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-fetch bus: memory read port plus the issue handshake and branch controls.
interface instr_fetch_if;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OPC_W  = 3;
  localparam int unsigned OPD_W  = 5;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_data;
  logic [OPC_W-1:0]  OPCode;
  logic [OPD_W-1:0]  operand;
  logic              instr_valid;
  logic              instr_ready;
  logic              J;
  logic              JC;
  logic              NEQ;
  logic              eq_flag;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, OPCode, operand, instr_valid,
    input  imem_ack, imem_data, instr_ready, J, JC, NEQ, eq_flag
  );

  // Memory / control-unit side
  modport slave (
    input  imem_req, imem_addr, OPCode, operand, instr_valid,
    output imem_ack, imem_data, instr_ready, J, JC, NEQ, eq_flag
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: fetches one word at pc, issues it, then steps or branches pc.
module instr_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  instr_fetch_if.master bus,
  output logic [7:0]    pc,
  output logic [15:0]   retired
);
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned OPC_W  = 3;
  localparam int unsigned OPD_W  = 5;
  localparam int unsigned RET_W  = 16;

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic [OPC_W-1:0]  opcode_q, opcode_d;
  logic [OPD_W-1:0]  operand_q, operand_d;
  logic [RET_W-1:0]  retired_q, retired_d;

  logic              taken_c;
  logic [ADDR_W-1:0] offset_c;
  logic [ADDR_W-1:0] target_c;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      operand_q <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, next-pc and registered-output logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    valid_d   = valid_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    retired_d = retired_q;

    // Branch decision only matters on the handshake cycle in ISSUE
    taken_c  = bus.J | (bus.JC & (bus.eq_flag ^ bus.NEQ));
    offset_c = {{(ADDR_W-OPD_W){operand_q[OPD_W-1]}}, operand_q};
    target_c = pc_q + offset_c;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = FETCH;
          req_d   = 1'b1;
        end
      end
      FETCH: begin
        if (bus.imem_ack) begin
          state_d   = ISSUE;
          req_d     = 1'b0;
          valid_d   = 1'b1;
          opcode_d  = bus.imem_data[7:5];
          operand_d = bus.imem_data[4:0];
        end
      end
      ISSUE: begin
        if (bus.instr_ready) begin
          valid_d   = 1'b0;
          pc_d      = taken_c ? target_c : pc_q + ADDR_W'(1);
          retired_d = retired_q + RET_W'(1);
          if (enable) begin
            state_d = FETCH;
            req_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Address is the flopped pc, so it is stable for the whole fetch
  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.OPCode      = opcode_q;
  assign bus.operand     = operand_q;
  assign bus.instr_valid = valid_q;
  assign pc              = pc_q;
  assign retired         = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table of fetch/issue transactions plus reset corner cases.
module tb_instr_fetch;
  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [7:0]  pc;
  logic [15:0] retired;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(8'h00)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .bus     (bus),
    .pc      (pc),
    .retired (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc;       // expected fetch address
    logic [7:0] data;     // word returned by memory
    int         ack_dly;  // FETCH cycles without ack
    int         rdy_dly;  // ISSUE cycles without ready
    logic       j, jc, neq, eq;
    logic       preload;  // force retired to FFFF before this instruction
    logic       en_hs;    // enable value during the handshake
    logic [7:0] pc_next;  // expected pc after the handshake
  } vec_t;

  localparam int NV = 21;
  vec_t        tbl [NV];
  int          total;
  int          bad;
  logic [15:0] exp_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] p, input logic [7:0] d, input int ad, input int rd,
                              input logic j, input logic jc, input logic neq, input logic eq,
                              input logic pre, input logic en, input logic [7:0] pn);
    vec_t v;
    v.pc = p; v.data = d; v.ack_dly = ad; v.rdy_dly = rd;
    v.j = j; v.jc = jc; v.neq = neq; v.eq = eq;
    v.preload = pre; v.en_hs = en; v.pc_next = pn;
    return v;
  endfunction

  // One complete fetch/issue transaction; called at a falling edge
  task automatic run_vec(input vec_t v);
    int         cnt;
    logic [2:0] opc;
    logic [4:0] opd;
    opc = v.data[7:5];
    opd = v.data[4:0];
    enable = 1'b1;
    cnt = 0;
    while (!bus.imem_req && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    chk("req_seen", 32'(bus.imem_req), 32'd1);
    chk("fetch_addr", 32'(bus.imem_addr), 32'(v.pc));
    if (v.preload) begin
      force dut.retired_q = 16'hFFFF;
      #1;
      release dut.retired_q;
      exp_ret = 16'hFFFF;
    end
    for (int i = 0; i < v.ack_dly; i++) begin
      bus.imem_ack  = 1'b0;
      bus.imem_data = 8'(i * 37 + 5);
      @(negedge clk);
      chk("stall_req", 32'(bus.imem_req), 32'd1);
      chk("stall_addr", 32'(bus.imem_addr), 32'(v.pc));
      chk("stall_novalid", 32'(bus.instr_valid), 32'd0);
    end
    bus.imem_ack  = 1'b1;
    bus.imem_data = v.data;
    @(negedge clk);
    bus.imem_ack  = 1'b0;
    bus.imem_data = ~v.data;
    chk("issue_valid", 32'(bus.instr_valid), 32'd1);
    chk("issue_req", 32'(bus.imem_req), 32'd0);
    chk("opcode", 32'(bus.OPCode), 32'(opc));
    chk("operand", 32'(bus.operand), 32'(opd));
    for (int i = 0; i < v.rdy_dly; i++) begin
      bus.instr_ready = 1'b0;
      bus.J = 1'b1; bus.JC = 1'b1; bus.NEQ = 1'b0; bus.eq_flag = 1'b1;
      @(negedge clk);
      chk("hold_valid", 32'(bus.instr_valid), 32'd1);
      chk("hold_opcode", 32'({bus.OPCode, bus.operand}), 32'({opc, opd}));
      chk("hold_retired", 32'(retired), 32'(exp_ret));
      chk("hold_pc", 32'(pc), 32'(v.pc));
    end
    bus.instr_ready = 1'b1;
    bus.J = v.j; bus.JC = v.jc; bus.NEQ = v.neq; bus.eq_flag = v.eq;
    enable = v.en_hs;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.J = 1'b0; bus.JC = 1'b0; bus.NEQ = 1'b0; bus.eq_flag = 1'b0;
    exp_ret = exp_ret + 16'd1;
    chk("post_valid", 32'(bus.instr_valid), 32'd0);
    chk("next_pc", 32'(pc), 32'(v.pc_next));
    chk("retired", 32'(retired), 32'(exp_ret));
    chk("post_req", 32'(bus.imem_req), 32'(v.en_hs));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    exp_ret = 16'h0000;

    //          pc     data   ad rd  J  JC NEQ eq pre en  pc_next
    tbl[0]  = mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 8'h01);
    tbl[1]  = mk(8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 8'h02);
    tbl[2]  = mk(8'h02, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 8'h03);
    tbl[3]  = mk(8'h03, 8'hAD, 0, 0, 1, 0, 0, 0, 0, 1, 8'h10);
    tbl[4]  = mk(8'h10, 8'h9E, 0, 0, 1, 0, 0, 0, 0, 1, 8'h0E);
    tbl[5]  = mk(8'h0E, 8'hCF, 0, 0, 1, 0, 0, 0, 0, 1, 8'h1D);
    tbl[6]  = mk(8'h1D, 8'hC3, 1, 0, 1, 0, 0, 0, 0, 1, 8'h20);
    tbl[7]  = mk(8'h20, 8'h64, 0, 0, 0, 1, 0, 0, 0, 1, 8'h21);
    tbl[8]  = mk(8'h21, 8'hDF, 0, 1, 1, 0, 0, 0, 0, 1, 8'h20);
    tbl[9]  = mk(8'h20, 8'h64, 0, 0, 0, 1, 0, 1, 0, 1, 8'h24);
    tbl[10] = mk(8'h24, 8'hDC, 0, 0, 1, 0, 0, 0, 0, 1, 8'h20);
    tbl[11] = mk(8'h20, 8'h64, 0, 0, 0, 1, 1, 0, 0, 1, 8'h24);
    tbl[12] = mk(8'h24, 8'h64, 0, 0, 0, 1, 1, 1, 0, 1, 8'h25);
    tbl[13] = mk(8'h25, 8'h55, 3, 4, 0, 0, 0, 0, 0, 1, 8'h26);
    tbl[14] = mk(8'h26, 8'hC0, 0, 0, 1, 0, 0, 0, 0, 1, 8'h26);
    tbl[15] = mk(8'h26, 8'hD0, 0, 0, 1, 0, 0, 0, 0, 1, 8'h16);
    tbl[16] = mk(8'h16, 8'hD0, 0, 0, 1, 0, 0, 0, 0, 1, 8'h06);
    tbl[17] = mk(8'h06, 8'hD0, 0, 0, 1, 0, 0, 0, 0, 1, 8'hF6);
    tbl[18] = mk(8'hF6, 8'hC9, 0, 0, 1, 0, 0, 0, 0, 1, 8'hFF);
    tbl[19] = mk(8'hFF, 8'h2A, 0, 0, 0, 1, 0, 0, 1, 1, 8'h00);
    tbl[20] = mk(8'h00, 8'hE0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h01);

    rst_n = 1'b0;
    enable = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_data = 8'h00;
    bus.instr_ready = 1'b0;
    bus.J = 1'b0; bus.JC = 1'b0; bus.NEQ = 1'b0; bus.eq_flag = 1'b0;
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_opcode", 32'({bus.OPCode, bus.operand}), 32'd0);
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_retired", 32'(retired), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_noreq", 32'(bus.imem_req), 32'd0);
    chk("idle_pc", 32'(pc), 32'h00);

    for (int k = 0; k < NV; k++) run_vec(tbl[k]);

    // Reset in the middle of a fetch at pc 01, then a stray ack after release
    @(negedge clk);
    chk("midfetch_req", 32'(bus.imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_req", 32'(bus.imem_req), 32'd0);
    chk("mrst_valid", 32'(bus.instr_valid), 32'd0);
    chk("mrst_opcode", 32'({bus.OPCode, bus.operand}), 32'd0);
    chk("mrst_pc", 32'(pc), 32'h00);
    chk("mrst_retired", 32'(retired), 32'd0);
    exp_ret = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_data = 8'hAB;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("stray_novalid", 32'(bus.instr_valid), 32'd0);
    chk("stray_req", 32'(bus.imem_req), 32'd1);
    chk("stray_opcode", 32'({bus.OPCode, bus.operand}), 32'd0);
    run_vec(mk(8'h00, 8'h23, 0, 0, 0, 0, 0, 0, 0, 1, 8'h01));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
